conv_seq_ctrl: RTL and testbench

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_credit_cnt.sv | 51 +++++
 rtl/conv_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencing controller.
// Contents:
//   state_t      - controller FSM states
//   CREDITS_DEF  - default depth of the issued-but-unreturned result window
//   NUM_PE, PIX_BITS, CH_PER_GROUP, WWORD_BITS - PE-array geometry
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CREDITS_DEF  = 4;
  localparam int NUM_PE       = 8;
  localparam int PIX_BITS     = 64;             // 8 int8 channels per pixel word
  localparam int CH_PER_GROUP = PIX_BITS / 8;
  localparam int WWORD_BITS   = 576;            // 8 PEs x 3x3 taps x int8

endpackage

// File: rtl/conv_credit_cnt.sv
// Outstanding pixel-result counter with protocol error detection.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   clr           - job start: zero the counter and clear the error
//   inc           - a pixel's last input group was issued
//   dec           - a pixel result came back from the PE array
//   idle          - controller is idle (any return now is spurious)
//   outstanding   - results issued but not yet returned, 0..CREDITS
//   full          - outstanding has reached CREDITS
//   err           - sticky: return with nothing outstanding, or while idle
module conv_credit_cnt #(
  parameter int CREDITS = 4,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  input  logic             idle,
  output logic [CNT_W-1:0] outstanding,
  output logic             full,
  output logic             err
);

  // Simultaneous inc/dec cancel; the count clamps at both ends.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt,
                                                input logic up, input logic down);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (up && !down && cnt != CNT_W'(CREDITS)) res = cnt + CNT_W'(1);
    else if (!up && down && cnt != '0)         res = cnt - CNT_W'(1);
    return res;
  endfunction

  assign full = (outstanding == CNT_W'(CREDITS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else if (clr) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (dec && (idle || outstanding == '0)) err <= 1'b1;
      outstanding <= sat_step(outstanding, inc, dec);
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for an 8-PE 3x3 convolution array. For each output pixel it
// walks the input-channel groups, presenting a weight address per group and
// flagging the last group, while limiting the number of pixels whose results
// have not yet come back from the PE array.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   start                    - job start pulse (accepted only when idle)
//   cfg_ci_groups/num_pix/wbase - job configuration, latched on start
//   busy, done, err          - job active, completion pulse, sticky error
//   win_valid, win_ready     - window source handshake (ready is combinational)
//   w_addr, b_addr           - weight / bias memory addresses
//   pe_valid_in, pe_last_channel - PE array controls, one cycle after issue
//   pe_data_valid            - PE result returned
//   res_cnt                  - results returned in the current job
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int CI_W    = 10,
  parameter int PIX_W   = 16,
  parameter int WADDR_W = 12,
  parameter int CREDITS = CREDITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CI_W-1:0]    cfg_ci_groups,
  input  logic [PIX_W-1:0]   cfg_num_pix,
  input  logic [WADDR_W-1:0] cfg_wbase,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               win_valid,
  output logic               win_ready,
  output logic [WADDR_W-1:0] w_addr,
  output logic [WADDR_W-1:0] b_addr,
  output logic               pe_valid_in,
  output logic               pe_last_channel,
  input  logic               pe_data_valid,
  output logic [PIX_W-1:0]   res_cnt
);

  localparam int CNT_W = $clog2(CREDITS + 1);

  state_t             state, state_nxt;
  logic [CI_W-1:0]    ci_groups_r, ci_cnt;
  logic [PIX_W-1:0]   num_pix_r, pix_cnt;
  logic [WADDR_W-1:0] wbase_r, w_addr_hold;
  logic [CNT_W-1:0]   outstanding;
  logic               credit_full, accept, issue, last_grp, last_pix;

  assign accept   = (state == IDLE) && start;
  assign last_grp = (ci_cnt == ci_groups_r - CI_W'(1));
  assign last_pix = (pix_cnt == num_pix_r - PIX_W'(1));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = (cfg_ci_groups == '0 || cfg_num_pix == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        // Only the last group consumes a credit, so only it can stall.
        issue = win_valid && (!last_grp || !credit_full);
        if (issue && last_grp && last_pix) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (outstanding == '0 && !pe_valid_in) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign win_ready = issue;
  // Address goes out in the issue cycle so the 1-cycle memory read lines up
  // with pe_valid_in; between issues the last address is held.
  assign w_addr    = issue ? (wbase_r + WADDR_W'(ci_cnt)) : w_addr_hold;
  assign b_addr    = wbase_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      ci_groups_r     <= '0;
      num_pix_r       <= '0;
      wbase_r         <= '0;
      ci_cnt          <= '0;
      pix_cnt         <= '0;
      w_addr_hold     <= '0;
      res_cnt         <= '0;
      pe_valid_in     <= 1'b0;
      pe_last_channel <= 1'b0;
    end else begin
      state           <= state_nxt;
      pe_valid_in     <= issue;
      pe_last_channel <= issue && last_grp;
      if (accept) begin
        ci_groups_r <= cfg_ci_groups;
        num_pix_r   <= cfg_num_pix;
        wbase_r     <= cfg_wbase;
        ci_cnt      <= '0;
        pix_cnt     <= '0;
        res_cnt     <= '0;
      end
      if (issue) begin
        w_addr_hold <= w_addr;
        if (last_grp) begin
          ci_cnt  <= '0;
          pix_cnt <= pix_cnt + PIX_W'(1);
        end else begin
          ci_cnt  <= ci_cnt + CI_W'(1);
        end
      end
      if (pe_data_valid && busy) res_cnt <= res_cnt + PIX_W'(1);
    end
  end

  conv_credit_cnt #(
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .clr         (accept),
    .inc         (issue && last_grp),
    .dec         (pe_data_valid),
    .idle        (state == IDLE),
    .outstanding (outstanding),
    .full        (credit_full),
    .err         (err)
  );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: directed job scenarios plus randomized jobs,
// checked cycle by cycle against a count-based model of the job.
module tb_conv_seq_ctrl;

  localparam int CREDITS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  cfg_ci_groups = '0;
  logic [15:0] cfg_num_pix = '0;
  logic [11:0] cfg_wbase = '0;
  logic        busy, done, err;
  logic        win_valid = 1'b0;
  logic        win_ready;
  logic [11:0] w_addr, b_addr;
  logic        pe_valid_in, pe_last_channel;
  logic        pe_data_valid = 1'b0;
  logic [15:0] res_cnt;

  conv_seq_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_ci_groups   (cfg_ci_groups),
    .cfg_num_pix     (cfg_num_pix),
    .cfg_wbase       (cfg_wbase),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .win_valid       (win_valid),
    .win_ready       (win_ready),
    .w_addr          (w_addr),
    .b_addr          (b_addr),
    .pe_valid_in     (pe_valid_in),
    .pe_last_channel (pe_last_channel),
    .pe_data_valid   (pe_data_valid),
    .res_cnt         (res_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Job model: issues so far, results owed, and the scheduled PE returns.
  int cyc = 0, start_cyc = 0, done_cyc = -1;
  int m_ci = 0, m_np = 0, m_wbase = 0, m_k = 0, m_out = 0;
  bit m_run = 0, prev_issue = 0, prev_last = 0, ret_en = 0;
  int lat_lo = 4, lat_hi = 4, last_due = 0;
  int ret_q[$];
  int n_iss = 0, n_pv = 0, n_lc = 0, n_done = 0, max_out = 0;
  bit busy_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_k = 0; m_out = 0; prev_issue = 0; prev_last = 0;
    ret_q.delete(); last_due = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_done"},   32'(done), 0);
    chk({tag, "_err"},    32'(err), 0);
    chk({tag, "_ready"},  32'(win_ready), 0);
    chk({tag, "_pv"},     32'(pe_valid_in), 0);
    chk({tag, "_lc"},     32'(pe_last_channel), 0);
    chk({tag, "_waddr"},  32'(w_addr), 0);
    chk({tag, "_baddr"},  32'(b_addr), 0);
    chk({tag, "_rescnt"}, 32'(res_cnt), 0);
    chk({tag, "_out"},    32'(dut.u_credit.outstanding), 0);
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, update model.
  task automatic cycle(input bit wv, input bit inj);
    bit due, pdv, exp_rdy, is_last;
    int grp, total, d;
    total = m_ci * m_np;
    due = (ret_q.size() > 0) && (ret_q[0] <= cyc);
    pdv = due || inj;
    win_valid = wv;
    pe_data_valid = pdv;
    @(negedge clk);
    grp = (m_ci > 0) ? (m_k % m_ci) : 0;
    is_last = (grp == m_ci - 1);
    exp_rdy = m_run && wv && (m_k < total) && (!is_last || m_out < CREDITS);
    chk("win_ready", 32'(win_ready), 32'(exp_rdy));
    chk("pe_valid_in", 32'(pe_valid_in), 32'(prev_issue));
    chk("pe_last_channel", 32'(pe_last_channel), 32'(prev_last));
    chk("outstanding", 32'(dut.u_credit.outstanding), 32'(m_out));
    if (exp_rdy) begin
      chk("w_addr", 32'(w_addr), 32'((m_wbase + grp) & 'hfff));
      chk("b_addr", 32'(b_addr), 32'(m_wbase));
      chk("busy_issue", 32'(busy), 1);
    end
    if (win_ready) n_iss++;
    if (pe_valid_in) n_pv++;
    if (pe_last_channel) n_lc++;
    if (busy) busy_seen = 1;
    if (done) begin n_done++; done_cyc = cyc; end
    if (int'(dut.u_credit.outstanding) > max_out) max_out = int'(dut.u_credit.outstanding);
    if (prev_last && ret_en) begin
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (d <= last_due) d = last_due + 1;
      ret_q.push_back(d);
      last_due = d;
    end
    @(posedge clk); #1;
    if (due) void'(ret_q.pop_front());
    if (exp_rdy && is_last) m_out++;
    if (pdv && m_out > 0) m_out--;
    prev_issue = exp_rdy;
    prev_last = exp_rdy && is_last;
    if (exp_rdy) m_k++;
    pe_data_valid = 1'b0;
    cyc++;
  endtask

  task automatic start_job(input int ci, input int np, input int wb);
    cfg_ci_groups = 10'(ci);
    cfg_num_pix = 16'(np);
    cfg_wbase = 12'(wb);
    start = 1'b1;
    win_valid = 1'b0;
    pe_data_valid = 1'b0;
    @(negedge clk);
    chk("busy_before_start", 32'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    m_ci = ci; m_np = np; m_wbase = wb; m_run = 1;
    n_iss = 0; n_pv = 0; n_lc = 0; n_done = 0; max_out = 0; busy_seen = 0;
    start_cyc = cyc;
    cyc++;
  endtask

  task automatic run_until_done(input int wprob, input int maxc);
    int i;
    i = 0;
    while (n_done == 0 && i < maxc) begin
      cycle($urandom_range(99, 0) < wprob, 1'b0);
      i++;
    end
    chk("done_within_bound", 32'(n_done), 1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("done_once", 32'(n_done), 1);
    chk("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;

    // 3 groups x 2 pixels, fixed 4-cycle PE latency.
    ret_en = 1; lat_lo = 4; lat_hi = 4;
    start_job(3, 2, 'h100);
    run_until_done(100, 200);
    chk("basic_issues", 32'(n_iss), 6);
    chk("basic_pv", 32'(n_pv), 6);
    chk("basic_lc", 32'(n_lc), 2);
    chk("basic_rescnt", 32'(res_cnt), 2);
    chk("basic_err", 32'(err), 0);

    // Zero channel groups: straight to done.
    start_job(0, 5, 'h40);
    repeat (3) cycle(1'b1, 1'b0);
    chk("zero_done_cnt", 32'(n_done), 1);
    chk("zero_done_lat", 32'(done_cyc - start_cyc), 1);
    chk("zero_busy", 32'(busy_seen), 0);
    chk("zero_pv", 32'(n_pv), 0);

    // Spurious return while idle sets a sticky error.
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    chk("err_set", 32'(err), 1);
    chk("err_busy", 32'(busy), 0);
    start_job(1, 1, 'h10);
    chk("err_cleared", 32'(err), 0);
    run_until_done(100, 100);
    chk("err_job_rescnt", 32'(res_cnt), 1);

    // Credit stall with no returns, then one credit back.
    ret_en = 0;
    start_job(1, 6, 'h20);
    repeat (10) cycle(1'b1, 1'b0);
    chk("stall_issues", 32'(n_iss), 4);
    chk("stall_ready", 32'(win_ready), 0);
    cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b1, 1'b0);
    chk("stall_one_more", 32'(n_iss), 5);
    chk("stall_err", 32'(err), 0);

    // Abandon the stalled job, then reset mid-run with two outstanding.
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    start_job(1, 6, 'h30);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    chk("mid_out", 32'(dut.u_credit.outstanding), 2);
    win_valid = 1'b1;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #3;
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    ret_en = 1; lat_lo = 4; lat_hi = 4;
    start_job(1, 1, 'h55);
    run_until_done(100, 100);
    chk("postrst_rescnt", 32'(res_cnt), 1);
    chk("postrst_issues", 32'(n_iss), 1);

    // Random window gaps and PE latencies.
    lat_lo = 1; lat_hi = 6;
    for (int j = 0; j < 5; j++) begin
      int ci, np, wb;
      ci = int'($urandom_range(4, 1));
      np = int'($urandom_range(7, 1));
      wb = int'($urandom_range(4095, 0));
      start_job(ci, np, wb);
      run_until_done(60, 3000);
      chk("rand_issues", 32'(n_iss), 32'(ci * np));
      chk("rand_rescnt", 32'(res_cnt), 32'(np));
      chk("rand_out_max", 32'(max_out <= CREDITS), 1);
      chk("rand_err", 32'(err), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
